// File: rtl/seq_gen.sv
// -----------------------------------------------------------------------------
// seq_gen -- serial pattern generator
//
// Captures a pattern of (len+1) bits on start and shifts it out MSB-first
// (bit len down to bit 0), one bit per clock, repeating it (reps+1) times.
// The serial output and its valid flag are registered. A one-cycle done
// pulse marks normal completion. abort cancels a transmission without a
// done pulse.
//
// Optional feature macro: SEQ_GEN_GAP_EN
//   When defined, a GAP state inserts one idle-looking cycle (out=0,
//   out_valid=0, busy=1) between consecutive repetitions. When undefined,
//   repetitions are sent back to back.
//
// Parameters:
//   WIDTH      maximum pattern length in bits (2..32)
//
// Ports:
//   clk        input   clock, rising-edge active
//   rst_n      input   asynchronous active-low reset
//   start      input   begin a transmission (sampled only in IDLE)
//   abort      input   synchronous cancel of a transmission in progress
//   pattern    input   [WIDTH-1:0] bits to transmit
//   len        input   [$clog2(WIDTH)-1:0] pattern length minus one
//   reps       input   [3:0] repetition count minus one
//   out        output  registered serial bit
//   out_valid  output  high while out carries a pattern bit
//   busy       output  high whenever the FSM is not IDLE
//   done       output  one-cycle pulse on normal completion
// -----------------------------------------------------------------------------
module seq_gen #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [WIDTH-1:0]           pattern,
    input  logic [$clog2(WIDTH)-1:0]   len,
    input  logic [3:0]                 reps,
    output logic                       out,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       done
);

    localparam int LW = $clog2(WIDTH);
    localparam logic [LW-1:0] IDX_ZERO = LW'(0);
    localparam logic [LW-1:0] IDX_ONE  = LW'(1);

`ifdef SEQ_GEN_GAP_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  pat_q,   pat_d;
    logic [LW-1:0]     len_q,   len_d;
    logic [3:0]        rep_q,   rep_d;
    logic [LW-1:0]     idx_q,   idx_d;
    logic              out_q,   out_d;
    logic              valid_q, valid_d;
    logic              done_q,  done_d;
    logic [LW-1:0]     idx_m1_s;

    // Next lower bit position while walking through the captured pattern.
    assign idx_m1_s = idx_q - IDX_ONE;

    // State, captured operands, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pat_q   <= {WIDTH{1'b0}};
            len_q   <= IDX_ZERO;
            rep_q   <= 4'd0;
            idx_q   <= IDX_ZERO;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            rep_q   <= rep_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; abort wins over every bit/repetition advance.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (idx_q != IDX_ZERO) begin
                    state_d = ST_SHIFT;
                end else if (rep_q != 4'd0) begin
`ifdef SEQ_GEN_GAP_EN
                    state_d = ST_GAP;
`else
                    state_d = ST_SHIFT;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
`ifdef SEQ_GEN_GAP_EN
            ST_GAP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and output next values; out/out_valid/done default low so
    // out is zero whenever it is not carrying a pattern bit.
    always_comb begin
        pat_d   = pat_q;
        len_d   = len_q;
        rep_d   = rep_q;
        idx_d   = idx_q;
        out_d   = 1'b0;
        valid_d = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pat_d   = pattern;
                    len_d   = len;
                    rep_d   = reps;
                    idx_d   = len;
                    out_d   = pattern[len];
                    valid_d = 1'b1;
                end else begin
                    valid_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    valid_d = 1'b0;
                end else if (idx_q != IDX_ZERO) begin
                    idx_d   = idx_m1_s;
                    out_d   = pat_q[idx_m1_s];
                    valid_d = 1'b1;
                end else if (rep_q != 4'd0) begin
                    rep_d = rep_q - 4'd1;
`ifdef SEQ_GEN_GAP_EN
                    // The restart happens on leaving GAP.
                    valid_d = 1'b0;
`else
                    idx_d   = len_q;
                    out_d   = pat_q[len_q];
                    valid_d = 1'b1;
`endif
                end else begin
                    done_d = 1'b1;
                end
            end
`ifdef SEQ_GEN_GAP_EN
            ST_GAP: begin
                if (abort) begin
                    valid_d = 1'b0;
                end else begin
                    idx_d   = len_q;
                    out_d   = pat_q[len_q];
                    valid_d = 1'b1;
                end
            end
`endif
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign done      = done_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_seq_gen -- directed self-checking bench for seq_gen (WIDTH=8).
// Each step advances one clock and compares {out,out_valid,busy,done}
// sampled on the falling edge against a hand-computed nibble.
// -----------------------------------------------------------------------------
module tb_seq_gen;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] pattern;
    logic [2:0] len;
    logic [3:0] reps;
    logic       out;
    logic       out_valid;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_err    = 0;
    logic prev_done = 1'b0;

    seq_gen #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .pattern   (pattern),
        .len       (len),
        .reps      (reps),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock; compare {out,out_valid,busy,done} at the falling edge.
    task automatic step(input string tag, input logic [3:0] exp);
        @(posedge clk);
        @(negedge clk);
        chk(tag, {out, out_valid, busy, done}, exp);
    endtask

    // Invariants checked every cycle.
    always @(negedge clk) begin
        chk("inv_busy_valid", {3'b000, (!busy && out_valid)}, 4'b0000);
        chk("inv_out_zero",   {3'b000, (!out_valid && out)},  4'b0000);
        chk("inv_done_twice", {3'b000, (done && prev_done)},  4'b0000);
        prev_done <= done;
    end

    logic [10:0] seq_o;
    logic [10:0] seq_v;
    int          seq_n;

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        pattern = 8'h00;
        len     = 3'd0;
        reps    = 4'd0;
        repeat (2) @(negedge clk);
        chk("reset", {out, out_valid, busy, done}, 4'b0000);
        rst_n = 1'b1;
        step("idle", 4'b0000);

        // 0x0B, len 3: bits 1,0,1,1; inputs change mid-transaction.
        pattern = 8'h0B; len = 3'd3; reps = 4'd0; start = 1'b1;
        step("t1_b3", 4'b1110);
        start = 1'b0;
        step("t1_b2", 4'b0110);
        start = 1'b1; pattern = 8'hF0; len = 3'd7; reps = 4'd5;
        step("t1_b1", 4'b1110);
        step("t1_b0", 4'b1110);
        start = 1'b0;
        step("t1_done", 4'b0001);
        step("t1_idle", 4'b0000);

        // 0x05, len 2, reps 2.
`ifdef SEQ_GEN_GAP_EN
        seq_o = 11'b10101010101;
        seq_v = 11'b11101110111;
        seq_n = 11;
`else
        seq_o = 11'b00101101101;
        seq_v = 11'b00111111111;
        seq_n = 9;
`endif
        pattern = 8'h05; len = 3'd2; reps = 4'd2; start = 1'b1;
        step("t2_first", {seq_o[seq_n-1], seq_v[seq_n-1], 1'b1, 1'b0});
        start = 1'b0;
        for (int i = seq_n - 2; i >= 0; i--) begin
            step("t2_bit", {seq_o[i], seq_v[i], 1'b1, 1'b0});
        end
        step("t2_done", 4'b0001);
        step("t2_idle", 4'b0000);

        // start held high, 1-bit pattern: new transaction every 2 cycles.
        pattern = 8'h01; len = 3'd0; reps = 4'd0; start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step("t3_bit", 4'b1110);
            step("t3_done", 4'b0001);
        end
        start = 1'b0;
        step("t3_idle", 4'b0000);

        // Abort at the edge that would drive the 3rd bit of 0xA5.
        pattern = 8'hA5; len = 3'd7; reps = 4'd0; start = 1'b1;
        step("t4_b7", 4'b1110);
        start = 1'b0;
        step("t4_b6", 4'b0110);
        abort = 1'b1;
        step("t4_abort", 4'b0000);
        abort = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step("t4_no_done", 4'b0000);
        end

        // abort together with start in IDLE: start wins.
        pattern = 8'h03; len = 3'd1; reps = 4'd0; start = 1'b1; abort = 1'b1;
        step("t5_b1", 4'b1110);
        start = 1'b0; abort = 1'b0;
        step("t5_b0", 4'b1110);
        step("t5_done", 4'b0001);
        step("t5_idle", 4'b0000);

        // Max reps, 2-bit pattern 10.
        pattern = 8'h02; len = 3'd1; reps = 4'd15; start = 1'b1;
        for (int r = 0; r < 16; r++) begin
            step("t6_hi", 4'b1110);
            start = 1'b0;
            step("t6_lo", 4'b0110);
`ifdef SEQ_GEN_GAP_EN
            if (r != 15) step("t6_gap", 4'b0010);
`endif
        end
        step("t6_done", 4'b0001);
        step("t6_idle", 4'b0000);

        // Asynchronous reset between edges mid-transaction.
        pattern = 8'hFF; len = 3'd7; reps = 4'd1; start = 1'b1;
        step("t7_b7", 4'b1110);
        start = 1'b0;
        step("t7_b6", 4'b1110);
        #2 rst_n = 1'b0;
        #1 chk("t7_async_rst", {out, out_valid, busy, done}, 4'b0000);
        #1 rst_n = 1'b1;
        step("t7_no_done", 4'b0000);
        step("t7_idle", 4'b0000);
        pattern = 8'h02; len = 3'd1; reps = 4'd0; start = 1'b1;
        step("t7_after_b1", 4'b1110);
        start = 1'b0;
        step("t7_after_b0", 4'b0110);
        step("t7_after_done", 4'b0001);
        step("t7_after_idle", 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
